pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipeline_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller.
//   ctrl_state_e : controller FSM states (RUN / SQUASH)
//   stage_ctrl_t : bundle of stage-register enables and bubble-inject flushes
//   CNT_W_DEF    : default performance-counter width
package pipe_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } ctrl_state_e;

  // Bit order matches {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FREEZE   = 7'b00000_00; // data memory stall
  localparam stage_ctrl_t CTRL_RUN      = 7'b11111_00; // normal advance
  localparam stage_ctrl_t CTRL_FLUSH    = 7'b11111_11; // redirect / reset fill
  localparam stage_ctrl_t CTRL_IF_BUB   = 7'b01111_10; // hold PC, bubble into IF/ID
  localparam stage_ctrl_t CTRL_LOAD_USE = 7'b00111_01; // hold IF/ID, bubble into ID/EX

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value; sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)                     count <= '0;
    else if (inc && ~&count)     count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/stall controller.
//   clk, rst                       : clock, synchronous active-high reset
//   load_use_stall                 : load-use hazard from the hazard detector
//   ex_redirect                    : taken branch/jump resolved in EX
//   imem_busy, dmem_busy           : instruction / data memory not ready
//   pc_en .. mem_wb_en             : stage-register load enables
//   if_id_flush, id_ex_flush       : load a NOP bubble (with matching _en)
//   stall_cycles, load_use_cnt,
//   redirect_cnt                   : saturating performance counters
//   ctrl_state                     : 0=RUN, 1=SQUASH (debug)
// SQUASH covers a redirect that happened while a fetch was still in flight:
// that fetch belongs to the wrong path and is bubbled when it finally lands.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             ex_redirect,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             ctrl_state
);

  ctrl_state_e state, state_nxt;
  stage_ctrl_t ctrl;
  logic        lu_hit, rd_hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (dmem_busy) begin
      state_nxt = state;
    end else if (ex_redirect) begin
      // A redirect while already squashing keeps squashing.
      if (state == SQUASH) state_nxt = SQUASH;
      else                 state_nxt = imem_busy ? SQUASH : RUN;
    end else if (state == SQUASH && !imem_busy) begin
      // Stale fetch lands this cycle and is bubbled.
      state_nxt = RUN;
    end
  end

  // Outputs: one priority row per cycle
  always_comb begin
    ctrl   = CTRL_RUN;
    lu_hit = 1'b0;
    rd_hit = 1'b0;
    if (rst) begin
      ctrl = CTRL_FLUSH;
    end else if (dmem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_redirect) begin
      ctrl   = CTRL_FLUSH;
      rd_hit = 1'b1;
    end else if (state == SQUASH) begin
      ctrl = CTRL_IF_BUB;
    end else if (load_use_stall) begin
      ctrl   = CTRL_LOAD_USE;
      lu_hit = 1'b1;
    end else if (imem_busy) begin
      ctrl = CTRL_IF_BUB;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ctrl_state  = state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_en && !rst),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lu_hit),
    .count (load_use_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rd_hit),
    .count (redirect_cnt)
  );

endmodule
